ram_bus_ctrl: RTL

Sequencer for the Nibbler's shared 4-bit RAM data bus. It sits directly upstream of the tri-state bus driver and feeds it the data word and the active-low drive enable. It also generates the RAM address, write strobe and output enable, and samples read data back from the bus. Its timing keeps the driver and the RAM from ever driving the bus in the same cycle.

---
 rtl/nibbler_bus_pkg.sv | 15 +
 rtl/ram_bus_timer.sv | 20 ++
 rtl/ram_bus_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/nibbler_bus_pkg.sv
// Shared types and constants for the Nibbler RAM bus sequencer.
package nibbler_bus_pkg;
  localparam int   BUS_CNT_W  = 4;
  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  typedef enum logic [2:0] {
    IDLE, W_SETUP, W_STROBE, W_HOLD, R_ACCESS, TURN
  } bus_state_t;

  // Phase lengths are counted down to zero, so N cycles load N-1.
  function automatic logic [BUS_CNT_W-1:0] cyc_load(input int n);
    return BUS_CNT_W'(n - 1);
  endfunction
endpackage

// File: rtl/ram_bus_timer.sv
// Loadable down-counter with zero flag; times every wait phase of the bus FSM.
module ram_bus_timer
  import nibbler_bus_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [BUS_CNT_W-1:0] load_val,
  output logic                 zero
);
  logic [BUS_CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/ram_bus_ctrl.sv
// Shared 4-bit RAM bus sequencer: Moore strobes keep driver and RAM off the bus together.
// Define RAM_BUS_CTRL_TURN_EN to insert a one-cycle TURN state after every read.
module ram_bus_ctrl
  import nibbler_bus_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 4,
  parameter int SETUP_CYC  = 1,
  parameter int HOLD_CYC   = 1,
  parameter int ACCESS_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we_n,
  output logic              mem_oe_n,
  output logic [DATA_W-1:0] drv_data,
  output logic              drv_en_n,
  input  logic [DATA_W-1:0] bus_in
);
  if (SETUP_CYC < 1 || SETUP_CYC > 15 || HOLD_CYC < 1 || HOLD_CYC > 15 ||
      ACCESS_CYC < 1 || ACCESS_CYC > 15) begin : g_bad_param
    $error("ram_bus_ctrl: SETUP_CYC, HOLD_CYC and ACCESS_CYC must be in 1..15");
  end

  bus_state_t           state, state_nxt;
  logic                 load, cnt_zero;
  logic [BUS_CNT_W-1:0] load_val;
  logic                 accept;

  assign accept = req_valid && (state == IDLE);

  ram_bus_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_val  = '0;
    case (state)
      IDLE: if (req_valid) begin
        load = 1'b1;
        if (req_we) begin
          state_nxt = W_SETUP;
          load_val  = cyc_load(SETUP_CYC);
        end else begin
          state_nxt = R_ACCESS;
          load_val  = cyc_load(ACCESS_CYC);
        end
      end
      W_SETUP:  if (cnt_zero) state_nxt = W_STROBE;
      W_STROBE: begin
        state_nxt = W_HOLD;
        load      = 1'b1;
        load_val  = cyc_load(HOLD_CYC);
      end
      W_HOLD:   if (cnt_zero) state_nxt = IDLE;
`ifdef RAM_BUS_CTRL_TURN_EN
      R_ACCESS: if (cnt_zero) state_nxt = TURN;
`else
      R_ACCESS: if (cnt_zero) state_nxt = IDLE;
`endif
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mem_addr  <= '0;
      drv_data  <= '0;
      rsp_rdata <= '0;
      rsp_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      // Registered so the pulse lands in TURN or the first IDLE cycle alike.
      rsp_valid <= (state == R_ACCESS) && cnt_zero;
      if ((state == R_ACCESS) && cnt_zero) rsp_rdata <= bus_in;
      if (accept) begin
        mem_addr <= req_addr;
        drv_data <= req_wdata;
      end
    end
  end

  assign req_ready = (state == IDLE);
  assign drv_en_n  = (state == W_SETUP || state == W_STROBE || state == W_HOLD) ? STROBE_ON : STROBE_OFF;
  assign mem_we_n  = (state == W_STROBE) ? STROBE_ON : STROBE_OFF;
  assign mem_oe_n  = (state == R_ACCESS) ? STROBE_ON : STROBE_OFF;
endmodule
